// File: rtl/change_dispenser.sv
// Change-return engine: pays a refund greedily from a per-denomination coin stock, one coin per cycle.
// Latency: first coin visible 1 cycle after accept; done pulse n+2 cycles after accept for n coins.
// Backpressure: o_req_ready only in IDLE; requests offered while busy are dropped, not queued.
module change_dispenser #(
    parameter int kNumCoins  = 3,
    parameter int COIN0_VAL  = 100,
    parameter int COIN1_VAL  = 500,
    parameter int COIN2_VAL  = 1000,
    parameter int INV_W      = 8,
    parameter int INIT_STOCK = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_req_valid,
    input  logic [31:0]                  i_req_amount,
    output logic                         o_req_ready,
    input  logic [kNumCoins-1:0]         i_refill,
    output logic [kNumCoins-1:0]         o_coin_out,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [31:0]                  o_shortfall,
    output logic [kNumCoins*INV_W-1:0]   o_stock
);

    // SETTLE is the cycle between the final (empty) selection and the done pulse.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_SETTLE   = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // Denomination values; indices past the three defined coins can never be selected.
    function automatic logic [31:0] coin_val(input int k);
        case (k)
            0:       coin_val = 32'(COIN0_VAL);
            1:       coin_val = 32'(COIN1_VAL);
            2:       coin_val = 32'(COIN2_VAL);
            default: coin_val = '1;
        endcase
    endfunction

    state_t                 state_q;
    logic [31:0]            remaining_q;
    logic [kNumCoins-1:0]   coin_out_q;
    logic                   done_q;
    logic [31:0]            shortfall_q;
    logic [INV_W-1:0]       stock_q [kNumCoins];
    logic [INV_W-1:0]       stock_d [kNumCoins];

    logic [kNumCoins-1:0]   sel_oh;
    logic [31:0]            sel_val;
    logic                   sel_vld;
    logic                   disp_en;

    // Greedy pick: ascending scan so the highest affordable, in-stock denomination wins.
    always_comb begin
        sel_oh  = '0;
        sel_val = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if ((coin_val(k) <= remaining_q) && (stock_q[k] != '0)) begin
                sel_oh    = '0;
                sel_oh[k] = 1'b1;
                sel_val   = coin_val(k);
            end
        end
    end

    assign sel_vld = |sel_oh;
    assign disp_en = (state_q == S_DISPENSE) && sel_vld;

    // Stock next-state: refill and eject of the same coin cancel; refill saturates at all-ones.
    always_comb begin
        for (int k = 0; k < kNumCoins; k++) begin
            stock_d[k] = stock_q[k];
            if (i_refill[k] && !(disp_en && sel_oh[k])) begin
                if (stock_q[k] != {INV_W{1'b1}}) begin
                    stock_d[k] = stock_q[k] + 1'b1;
                end
            end else if (!i_refill[k] && disp_en && sel_oh[k]) begin
                stock_d[k] = stock_q[k] - 1'b1;
            end
        end
    end

    // Inventory registers, restocked to the initial count on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < kNumCoins; k++) begin
                stock_q[k] <= INV_W'(INIT_STOCK);
            end
        end else begin
            for (int k = 0; k < kNumCoins; k++) begin
                stock_q[k] <= stock_d[k];
            end
        end
    end

    // Request FSM with registered coin pulse, done pulse and shortfall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            coin_out_q  <= '0;
            done_q      <= 1'b0;
            shortfall_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    coin_out_q <= '0;
                    done_q     <= 1'b0;
                    if (i_req_valid) begin
                        remaining_q <= i_req_amount;
                        state_q     <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (sel_vld) begin
                        coin_out_q  <= sel_oh;
                        remaining_q <= remaining_q - sel_val;
                    end else begin
                        coin_out_q  <= '0;
                        shortfall_q <= remaining_q;
                        state_q     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    coin_out_q <= '0;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    coin_out_q <= '0;
                    done_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    coin_out_q <= '0;
                    done_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Pack inventory for observation, coin 0 in the LSBs.
    always_comb begin
        o_stock = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            o_stock[k*INV_W +: INV_W] = stock_q[k];
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_coin_out  = coin_out_q;
    assign o_done      = done_q;
    assign o_shortfall = shortfall_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic [31:0] i_req_amount = '0;
    logic        o_req_ready;
    logic [2:0]  i_refill = '0;
    logic [2:0]  o_coin_out;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_shortfall;
    logic [23:0] o_stock;

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_amount (i_req_amount),
        .o_req_ready  (o_req_ready),
        .i_refill     (i_refill),
        .o_coin_out   (o_coin_out),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_shortfall  (o_shortfall),
        .o_stock      (o_stock)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [2:0]  exp_coin_q [$];
    logic [31:0] exp_short_q [$];
    int          mstock [3];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          first_coin_cyc = -1;
    int          acc_cyc = 0;
    logic [2:0]  mon_coin;
    logic [31:0] mon_short;

    function automatic int val(input int k);
        case (k)
            0: val = 100;
            1: val = 500;
            default: val = 1000;
        endcase
    endfunction

    function automatic logic [23:0] model_stock();
        model_stock = {8'(mstock[2]), 8'(mstock[1]), 8'(mstock[0])};
    endfunction

    // Scoreboard consumer: pops expected coins and shortfalls as the DUT produces them.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (o_coin_out !== 3'b000) begin
                n_checks++;
                if (first_coin_cyc < 0) first_coin_cyc = cyc;
                if (exp_coin_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL coin_unexpected: got %b, required no coin", o_coin_out);
                end else begin
                    mon_coin = exp_coin_q.pop_front();
                    if (o_coin_out !== mon_coin) begin
                        n_fail++;
                        $display("FAIL coin_value: got %b, required %b", o_coin_out, mon_coin);
                    end
                end
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                n_checks++;
                if (exp_short_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got done with shortfall %0d, required no done", o_shortfall);
                end else begin
                    mon_short = exp_short_q.pop_front();
                    if (o_shortfall !== mon_short) begin
                        n_fail++;
                        $display("FAIL shortfall: got %0d, required %0d", o_shortfall, mon_short);
                    end
                end
                n_checks++;
                if (o_busy !== 1'b1 || o_req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_flags: got busy=%b ready=%b, required busy=1 ready=0", o_busy, o_req_ready);
                end
            end
        end
    endtask

    // Greedy reference: push expected pulses and shortfall, update model stock.
    task automatic push_model(input int amount, output int n);
        int rem;
        int pick;
        logic [2:0] oh;
        rem = amount;
        n = 0;
        do begin
            pick = -1;
            for (int k = 0; k < 3; k++) begin
                if (val(k) <= rem && mstock[k] > 0) pick = k;
            end
            if (pick >= 0) begin
                oh = '0;
                oh[pick] = 1'b1;
                exp_coin_q.push_back(oh);
                mstock[pick]--;
                rem -= val(pick);
                n++;
            end
        end while (pick >= 0);
        exp_short_q.push_back(32'(rem));
    endtask

    task automatic issue(input logic [31:0] amount);
        int t;
        t = 0;
        while (o_req_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=%b, required 1", o_req_ready);
        end
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_amount = amount;
        first_coin_cyc = -1;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_req_amount = $urandom;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int n);
        int start;
        int t;
        start = done_cnt;
        t = 0;
        while (done_cnt == start && t < 500) begin
            @(posedge clk);
            t++;
        end
        n_checks++;
        if (done_cnt == start) begin
            n_fail++;
            $display("FAIL done_timeout: got no done, required done after %0d coins", n);
        end else begin
            n_checks++;
            if (done_cyc != acc_cyc + n + 2) begin
                n_fail++;
                $display("FAIL done_latency: got edge N+%0d, required N+%0d", done_cyc - acc_cyc, n + 2);
            end
            if (n > 0) begin
                n_checks++;
                if (first_coin_cyc != acc_cyc + 1) begin
                    n_fail++;
                    $display("FAIL first_coin_latency: got edge N+%0d, required N+1", first_coin_cyc - acc_cyc);
                end
            end
        end
        n_checks++;
        if (exp_coin_q.size() != 0 || exp_short_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d coins %0d shortfalls pending, required 0", exp_coin_q.size(), exp_short_q.size());
        end
        exp_coin_q.delete();
        exp_short_q.delete();
        @(negedge clk);
        n_checks++;
        if (o_stock !== model_stock()) begin
            n_fail++;
            $display("FAIL stock: got %h, required %h", o_stock, model_stock());
        end
        t = 0;
        while (o_req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_coin_q.delete();
        exp_short_q.delete();
        for (int k = 0; k < 3; k++) mstock[k] = 10;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) mstock[k] = 10;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", o_req_ready); end
        n_checks++;
        if (o_coin_out !== 3'b000) begin n_fail++; $display("FAIL reset_coin: got %b, required 000", o_coin_out); end
        n_checks++;
        if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", o_done); end
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", o_busy); end
        n_checks++;
        if (o_shortfall !== 32'd0) begin n_fail++; $display("FAIL reset_shortfall: got %0d, required 0", o_shortfall); end
        n_checks++;
        if (o_stock !== 24'h0A0A0A) begin n_fail++; $display("FAIL reset_stock: got %h, required 0a0a0a", o_stock); end
    endtask

    task automatic test_basic();
        int n;
        push_model(1600, n);
        issue(1600);
        wait_done(n);
        n_checks++;
        if (o_stock !== 24'h090909) begin n_fail++; $display("FAIL basic_stock: got %h, required 090909", o_stock); end
        n_checks++;
        if (o_shortfall !== 32'd0) begin n_fail++; $display("FAIL basic_shortfall: got %0d, required 0", o_shortfall); end
    endtask

    task automatic test_scarce();
        int n;
        apply_reset();
        push_model(15000, n);
        issue(15000);
        wait_done(n);
        push_model(800, n);
        issue(800);
        wait_done(n);
        push_model(1300, n);
        issue(1300);
        wait_done(n);
        n_checks++;
        if (o_stock[7:0] !== 8'd0) begin n_fail++; $display("FAIL scarce_coin0: got %0d, required 0", o_stock[7:0]); end
        n_checks++;
        if (o_shortfall !== 32'd1100) begin n_fail++; $display("FAIL scarce_shortfall: got %0d, required 1100", o_shortfall); end
    endtask

    task automatic test_zero_and_odd();
        int n;
        int start;
        apply_reset();
        push_model(0, n);
        issue(0);
        wait_done(n);
        push_model(150, n);
        issue(150);
        start = done_cnt;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_amount = 32'd500;
        @(negedge clk);
        i_req_valid = 1'b0;
        wait_done(n);
        repeat (10) @(negedge clk);
        n_checks++;
        if (done_cnt != start + 1) begin n_fail++; $display("FAIL busy_ignored: got %0d dones, required 1", done_cnt - start); end
        n_checks++;
        if (o_shortfall !== 32'd50) begin n_fail++; $display("FAIL odd_shortfall: got %0d, required 50", o_shortfall); end
    endtask

    task automatic test_refill();
        int n;
        apply_reset();
        push_model(15000, n);
        issue(15000);
        wait_done(n);
        push_model(900, n);
        issue(900);
        wait_done(n);
        repeat (3) exp_coin_q.push_back(3'b001);
        exp_short_q.push_back(32'd0);
        issue(300);
        i_refill = 3'b001;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_refill = 3'b000;
        mstock[0] = 0;
        wait_done(3);
        for (int i = mstock[2]; i < 258; i++) begin
            @(negedge clk);
            i_refill = 3'b100;
        end
        @(negedge clk);
        i_refill = 3'b000;
        mstock[2] = 255;
        @(negedge clk);
        n_checks++;
        if (o_stock[23:16] !== 8'd255) begin n_fail++; $display("FAIL refill_saturate: got %0d, required 255", o_stock[23:16]); end
    endtask

    task automatic test_async_reset();
        int n;
        int start;
        apply_reset();
        push_model(2000, n);
        issue(2000);
        @(posedge clk);
        #1;
        n_checks++;
        if (o_coin_out !== 3'b100) begin n_fail++; $display("FAIL abort_first_coin: got %b, required 100", o_coin_out); end
        start = done_cnt;
        #2;
        reset = 1'b1;
        #1;
        exp_coin_q.delete();
        exp_short_q.delete();
        for (int k = 0; k < 3; k++) mstock[k] = 10;
        n_checks++;
        if (o_coin_out !== 3'b000) begin n_fail++; $display("FAIL abort_coin_clear: got %b, required 000", o_coin_out); end
        n_checks++;
        if (o_stock !== 24'h0A0A0A) begin n_fail++; $display("FAIL abort_stock: got %h, required 0a0a0a", o_stock); end
        n_checks++;
        if (o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b ready=%b, required busy=0 ready=1", o_busy, o_req_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (done_cnt != start) begin n_fail++; $display("FAIL abort_no_done: got %0d dones, required 0", done_cnt - start); end
        push_model(600, n);
        issue(600);
        wait_done(n);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_basic();
        test_scarce();
        test_zero_and_odd();
        test_refill();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
